// File: rtl/m68k_bus_sequencer.sv
// 68000-style asynchronous bus cycle sequencer driven by MC clock edge strobes.
// Walks S0..S7 per host request and reports completion or timeout via ACK/ERR.
module m68k_bus_sequencer #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic        MCCLK_FALLING,
  input  logic        MCCLK_RISING,
  input  logic        DTACK_LATCH,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [1:0]  REQ_BE,
  input  logic [22:0] REQ_ADDR,
  input  logic [15:0] REQ_WDATA,
  output logic        ACK,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic [22:0] BUS_ADDR,
  output logic        BUS_AS,
  output logic        BUS_UDS,
  output logic        BUS_LDS,
  output logic        BUS_RW,
  output logic [15:0] BUS_DOUT,
  output logic        BUS_DOE,
  input  logic [15:0] BUS_DIN
);

  typedef enum logic [2:0] {IDLE, S0, S2, S3, S4W, S6, S7, REL} state_t;

  state_t      state, state_d;
  logic        rw_q, rw_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [22:0] addr_d;
  logic        as_d, uds_d, lds_d, bus_rw_d, doe_d, ack_d, err_out_d;
  logic [15:0] dout_d, rdata_d;
  logic        fall, rise;

  // Coincident strobes are ambiguous, so neither one counts.
  assign fall = MCCLK_FALLING & ~MCCLK_RISING;
  assign rise = MCCLK_RISING & ~MCCLK_FALLING;
  assign BUSY = (state != IDLE);

  always_comb begin
    state_d   = state;
    rw_d      = rw_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    addr_d    = BUS_ADDR;
    as_d      = BUS_AS;
    uds_d     = BUS_UDS;
    lds_d     = BUS_LDS;
    bus_rw_d  = BUS_RW;
    dout_d    = BUS_DOUT;
    doe_d     = BUS_DOE;
    rdata_d   = RDATA;
    ack_d     = 1'b0;
    err_out_d = 1'b0;
    case (state)
      IDLE: if (REQ && fall) begin
        rw_d     = REQ_RW;
        be_d     = REQ_BE;
        wdata_d  = REQ_WDATA;
        err_d    = (REQ_BE == 2'b00);
        addr_d   = REQ_ADDR;
        bus_rw_d = REQ_RW;
        state_d  = S0;
      end
      S0: if (rise) begin
        as_d = 1'b0;
        if (rw_q) begin
          uds_d = ~be_q[1];
          lds_d = ~be_q[0];
        end
        state_d = S2;
      end
      S2: if (fall) begin
        if (!rw_q) begin
          doe_d  = 1'b1;
          dout_d = wdata_q;
        end
        state_d = S3;
      end
      S3: if (rise) begin
        if (!rw_q) begin
          uds_d = ~be_q[1];
          lds_d = ~be_q[0];
        end
        cnt_d   = '0;
        state_d = S4W;
      end
      S4W: if (fall) begin
        if (DTACK_LATCH) begin
          state_d = S6;
        end else if (cnt_q == TIMEOUT) begin
          err_d   = 1'b1;
          state_d = S7;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S6: if (rise) state_d = S7;
      S7: if (fall) begin
        if (rw_q && !err_q) rdata_d = BUS_DIN;
        as_d      = 1'b1;
        uds_d     = 1'b1;
        lds_d     = 1'b1;
        ack_d     = 1'b1;
        err_out_d = err_q;
        state_d   = REL;
      end
      REL: if (rise) begin
        doe_d    = 1'b0;
        bus_rw_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge SYSCLK) begin
    if (RESET) begin
      state    <= IDLE;
      rw_q     <= 1'b1;
      be_q     <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      BUS_ADDR <= '0;
      BUS_AS   <= 1'b1;
      BUS_UDS  <= 1'b1;
      BUS_LDS  <= 1'b1;
      BUS_RW   <= 1'b1;
      BUS_DOUT <= '0;
      BUS_DOE  <= 1'b0;
      RDATA    <= '0;
      ACK      <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state    <= state_d;
      rw_q     <= rw_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      BUS_ADDR <= addr_d;
      BUS_AS   <= as_d;
      BUS_UDS  <= uds_d;
      BUS_LDS  <= lds_d;
      BUS_RW   <= bus_rw_d;
      BUS_DOUT <= dout_d;
      BUS_DOE  <= doe_d;
      RDATA    <= rdata_d;
      ACK      <= ack_d;
      ERR      <= err_out_d;
    end
  end

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// Self-checking bench for m68k_bus_sequencer: MC clock strobes are generated here and
// each bus cycle is checked against a transaction-level model of the cycle timing.
module tb_m68k_bus_sequencer;

  localparam logic [7:0] TO   = 8'd4;
  localparam int         TO_I = int'(TO);

  logic        SYSCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MCCLK_FALLING = 1'b0, MCCLK_RISING = 1'b0, DTACK_LATCH = 1'b0;
  logic        REQ = 1'b0, REQ_RW = 1'b1;
  logic [1:0]  REQ_BE = 2'b11;
  logic [22:0] REQ_ADDR = '0;
  logic [15:0] REQ_WDATA = '0, BUS_DIN = '0;
  logic        ACK, ERR, BUSY, BUS_AS, BUS_UDS, BUS_LDS, BUS_RW, BUS_DOE;
  logic [15:0] RDATA, BUS_DOUT;
  logic [22:0] BUS_ADDR;

  m68k_bus_sequencer #(.TIMEOUT(TO)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .MCCLK_FALLING(MCCLK_FALLING), .MCCLK_RISING(MCCLK_RISING),
    .DTACK_LATCH(DTACK_LATCH), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_BE(REQ_BE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .BUSY(BUSY), .BUS_ADDR(BUS_ADDR),
    .BUS_AS(BUS_AS), .BUS_UDS(BUS_UDS), .BUS_LDS(BUS_LDS), .BUS_RW(BUS_RW), .BUS_DOUT(BUS_DOUT),
    .BUS_DOE(BUS_DOE), .BUS_DIN(BUS_DIN)
  );

  always #5 SYSCLK = ~SYSCLK;

  int checks = 0, errors = 0, ack_cnt = 0;
  logic [15:0] rdata_exp = '0, dout_exp = '0;

  always @(posedge SYSCLK) if (ACK === 1'b1) ack_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One strobe; DUT acts on the negedge, outputs are sampled at the following posedge.
  task automatic strobe(input bit f);
    MCCLK_FALLING = f;
    MCCLK_RISING  = !f;
    @(posedge SYSCLK);
    MCCLK_FALLING = 1'b0;
    MCCLK_RISING  = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 3)) @(posedge SYSCLK);
  endtask

  // Full bus cycle with expected values computed from the protocol rules.
  task automatic do_cycle(input bit rw, input logic [1:0] be, input logic [22:0] addr,
                          input logic [15:0] wd, input logic [15:0] din, input int d,
                          input bit drop_req, input bit keep_req, input bit dual, input int rst_at);
    int  acks0, nf, nf_exp;
    bit  got, exp_err;
    logic ack_s, err_s;
    logic [1:0] be_n;
    exp_err = (be == 2'b00) || (d > TO_I);
    nf_exp  = ((d < TO_I) ? d : TO_I) + 2;
    be_n    = ~be;
    acks0   = ack_cnt;
    got = 1'b0; nf = 0; ack_s = 1'b0; err_s = 1'b0;
    REQ = 1'b1; REQ_RW = rw; REQ_BE = be; REQ_ADDR = addr; REQ_WDATA = wd;
    BUS_DIN = din; DTACK_LATCH = 1'b0;

    strobe(1'b1);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL accept_busy: got %b exp 1", BUSY); end
    checks++; if (BUS_ADDR !== addr) begin errors++; $display("FAIL accept_addr: got %h exp %h", BUS_ADDR, addr); end
    checks++; if (BUS_RW !== rw) begin errors++; $display("FAIL accept_rw: got %b exp %b", BUS_RW, rw); end
    // Request fields now change; the cycle must keep using the latched copy.
    REQ_RW = !rw; REQ_BE = ~be; REQ_ADDR = 23'($urandom); REQ_WDATA = 16'($urandom);
    if (drop_req) REQ = 1'b0;
    gap();

    if (dual) begin
      MCCLK_FALLING = 1'b1; MCCLK_RISING = 1'b1;
      @(posedge SYSCLK);
      MCCLK_FALLING = 1'b0; MCCLK_RISING = 1'b0;
      checks++; if (BUS_AS !== 1'b1) begin errors++; $display("FAIL dual_s0_as: got %b exp 1", BUS_AS); end
      gap();
    end

    strobe(1'b0);
    checks++; if (BUS_AS !== 1'b0) begin errors++; $display("FAIL s0_as: got %b exp 0", BUS_AS); end
    checks++; if (BUS_UDS !== (rw ? be_n[1] : 1'b1)) begin errors++; $display("FAIL s0_uds: got %b exp %b", BUS_UDS, rw ? be_n[1] : 1'b1); end
    checks++; if (BUS_LDS !== (rw ? be_n[0] : 1'b1)) begin errors++; $display("FAIL s0_lds: got %b exp %b", BUS_LDS, rw ? be_n[0] : 1'b1); end
    gap();

    strobe(1'b1);
    if (!rw) dout_exp = wd;
    checks++; if (BUS_DOE !== !rw) begin errors++; $display("FAIL s2_doe: got %b exp %b", BUS_DOE, !rw); end
    checks++; if (BUS_DOUT !== dout_exp) begin errors++; $display("FAIL s2_dout: got %h exp %h", BUS_DOUT, dout_exp); end
    gap();

    strobe(1'b0);
    checks++; if (BUS_UDS !== be_n[1]) begin errors++; $display("FAIL s3_uds: got %b exp %b", BUS_UDS, be_n[1]); end
    checks++; if (BUS_LDS !== be_n[0]) begin errors++; $display("FAIL s3_lds: got %b exp %b", BUS_LDS, be_n[0]); end
    gap();

    for (int k = 0; k < 20 && !got; k++) begin
      DTACK_LATCH = (k >= d);
      if (rst_at >= 0 && k == rst_at) begin
        RESET = 1'b1;
        @(posedge SYSCLK);
        RESET = 1'b0; REQ = 1'b0; DTACK_LATCH = 1'b0;
        rdata_exp = '0; dout_exp = '0;
        checks++; if ({BUS_AS, BUS_UDS, BUS_LDS} !== 3'b111) begin errors++; $display("FAIL rst_strobes: got %b exp 111", {BUS_AS, BUS_UDS, BUS_LDS}); end
        checks++; if (BUS_DOE !== 1'b0) begin errors++; $display("FAIL rst_doe: got %b exp 0", BUS_DOE); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", BUSY); end
        checks++; if (BUS_RW !== 1'b1) begin errors++; $display("FAIL rst_rw: got %b exp 1", BUS_RW); end
        checks++; if (RDATA !== rdata_exp) begin errors++; $display("FAIL rst_rdata: got %h exp %h", RDATA, rdata_exp); end
        gap();
        checks++; if (ack_cnt - acks0 !== 0) begin errors++; $display("FAIL rst_no_ack: got %0d exp 0", ack_cnt - acks0); end
        return;
      end
      strobe(1'b1);
      nf++;
      if (ACK === 1'b1) begin got = 1'b1; ack_s = ACK; err_s = ERR; end
      gap();
      if (!got) begin strobe(1'b0); gap(); end
    end

    if (rw && !exp_err) rdata_exp = din;
    checks++; if (nf !== nf_exp) begin errors++; $display("FAIL ack_timing: got %0d falls exp %0d (ack=%b)", nf, nf_exp, ack_s); end
    checks++; if (err_s !== exp_err) begin errors++; $display("FAIL ack_err: got %b exp %b", err_s, exp_err); end
    checks++; if (RDATA !== rdata_exp) begin errors++; $display("FAIL rdata: got %h exp %h", RDATA, rdata_exp); end
    checks++; if ({BUS_AS, BUS_UDS, BUS_LDS} !== 3'b111) begin errors++; $display("FAIL s7_strobes: got %b exp 111", {BUS_AS, BUS_UDS, BUS_LDS}); end
    DTACK_LATCH = 1'b0;
    if (!keep_req) REQ = 1'b0;
    else begin REQ_RW = rw; REQ_BE = be; end

    strobe(1'b0);
    checks++; if (BUS_DOE !== 1'b0) begin errors++; $display("FAIL rel_doe: got %b exp 0", BUS_DOE); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rel_busy: got %b exp 0", BUSY); end
    checks++; if (BUS_RW !== 1'b1) begin errors++; $display("FAIL rel_rw: got %b exp 1", BUS_RW); end
    gap();
    checks++; if (ack_cnt - acks0 !== 1) begin errors++; $display("FAIL ack_count: got %0d exp 1", ack_cnt - acks0); end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge SYSCLK);
    checks++; if ({BUS_AS, BUS_UDS, BUS_LDS, BUS_RW} !== 4'b1111) begin errors++; $display("FAIL reset_strobes_rw: got %b exp 1111", {BUS_AS, BUS_UDS, BUS_LDS, BUS_RW}); end
    checks++; if ({BUS_DOE, ACK, ERR, BUSY} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {BUS_DOE, ACK, ERR, BUSY}); end
    checks++; if (RDATA !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0000", RDATA); end
    checks++; if (BUS_ADDR !== 23'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", BUS_ADDR); end
    checks++; if (BUS_DOUT !== 16'h0) begin errors++; $display("FAIL reset_dout: got %h exp 0000", BUS_DOUT); end
    RESET = 1'b0;
    @(posedge SYSCLK);
  endtask

  task automatic test_read_basic();
    do_cycle(1'b1, 2'b11, 23'h123456, 16'h0, 16'hA5C3, 0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_write_upper();
    do_cycle(1'b0, 2'b10, 23'h00ABCD, 16'hBEEF, 16'h1111, 0, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_timeout();
    do_cycle(1'b1, 2'b01, 23'h7FFFFF, 16'h0, 16'h5A5A, 99, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_wait_states();
    do_cycle(1'b1, 2'b11, 23'h000001, 16'h0, 16'h3C3C, 3, 1'b0, 1'b0, 1'b0, -1);
    do_cycle(1'b1, 2'b11, 23'h000002, 16'h0, 16'h4D4D, TO_I, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_be_zero();
    do_cycle(1'b1, 2'b00, 23'h055555, 16'h0, 16'hFFFF, 0, 1'b0, 1'b0, 1'b0, -1);
    do_cycle(1'b0, 2'b00, 23'h02AAAA, 16'h1234, 16'h0, 1, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_simultaneous();
    REQ = 1'b1; REQ_RW = 1'b1; REQ_BE = 2'b11;
    MCCLK_FALLING = 1'b1; MCCLK_RISING = 1'b1;
    @(posedge SYSCLK);
    MCCLK_FALLING = 1'b0; MCCLK_RISING = 1'b0;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL dual_idle_busy: got %b exp 0", BUSY); end
    REQ = 1'b0;
    gap();
    do_cycle(1'b0, 2'b01, 23'h0F0F0F, 16'hCAFE, 16'h0, 2, 1'b0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    do_cycle(1'b0, 2'b11, 23'h111111, 16'h7777, 16'h0, 99, 1'b0, 1'b0, 1'b0, 2);
    do_cycle(1'b1, 2'b11, 23'h222222, 16'h0, 16'h9999, 1, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    do_cycle(1'b1, 2'b11, 23'h333333, 16'h0, 16'h1357, 0, 1'b0, 1'b1, 1'b0, -1);
    do_cycle(1'b1, 2'b11, 23'h444444, 16'h0, 16'h2468, 1, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bit rw, drop, keep;
      logic [1:0] be;
      int d;
      rw   = 1'($urandom_range(0, 1));
      be   = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      d    = ($urandom_range(0, 4) == 0) ? 99 : int'($urandom_range(0, 6));
      drop = 1'($urandom_range(0, 1));
      keep = (i < 23) && ($urandom_range(0, 1) == 1);
      do_cycle(rw, be, 23'($urandom), 16'($urandom), 16'($urandom), d, drop, keep, 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_upper();
    test_timeout();
    test_wait_states();
    test_be_zero();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
